// File: rtl/sdr_cmd_pkg.sv
// Shared constants, opcode helpers and FSM state type for the SDR tuning
// command parser and its response sequencer.
package sdr_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam logic [7:0] OP_SET_FREQ  = 8'h01;
    localparam logic [7:0] OP_SET_DECIM = 8'h02;
    localparam logic [7:0] OP_READ_FREQ = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHK,
        ST_RESP,
        ST_RESP_WAIT
    } state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_SET_FREQ) || (op == OP_SET_DECIM) || (op == OP_READ_FREQ);
    endfunction

    function automatic logic [3:0] payload_len(input logic [7:0] op);
        case (op)
            OP_SET_FREQ:  return 4'd8;
            OP_SET_DECIM: return 4'd2;
            default:      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/sdr_tx_seq.sv
// Response byte sequencer: holds the byte on tx_byte and, on each advance,
// steps through up to eight bytes of a 64-bit source, MSB first.
module sdr_tx_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [7:0]  i_first,
    input  logic [3:0]  i_count,
    input  logic [63:0] i_src,
    input  logic        i_next,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic [7:0]  r_byte;
    logic [63:0] r_shift;
    logic [3:0]  r_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte  <= 8'h00;
            r_shift <= 64'h0;
            r_left  <= 4'd0;
        end else if (i_load) begin
            // i_count is the number of source bytes that follow the first byte
            r_byte  <= i_first;
            r_shift <= i_src;
            r_left  <= i_count;
        end else if (i_next && (r_left != 4'd0)) begin
            r_byte  <= r_shift[63:56];
            r_shift <= {r_shift[55:0], 8'h00};
            r_left  <= r_left - 4'd1;
        end
    end

    assign o_byte = r_byte;
    assign o_last = (r_left == 4'd0);

endmodule

// File: rtl/sdr_tune_ctrl.sv
// Framed-command configuration controller: parses A5/CMD/payload/CHK frames,
// commits NCO phase increment or CIC decimation atomically and acknowledges each frame.
module sdr_tune_ctrl
    import sdr_cmd_pkg::*;
#(
    parameter logic [63:0] PHASE_INC_RST = 64'h00000C56106EA3BC,
    parameter logic [15:0] DECIM_RST     = 16'd1024,
    parameter int          TIMEOUT_CYC   = 46200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic [63:0] phase_inc,
    output logic [15:0] decimation_ratio,
    output logic        cfg_update,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state
);

    // Handshake: rx_dv, tx_dv and tx_done are single-cycle valid strobes with no
    // back-pressure. tx_dv is raised only after the previous byte's tx_done, and
    // tx_byte stays stable from tx_dv until the matching tx_done.

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cmd;
    logic [3:0]  r_left;
    logic [7:0]  r_xor;
    logic [63:0] r_stage;
    logic [63:0] r_phase;
    logic [15:0] r_decim;
    logic        r_cfg_update;
    logic [7:0]  r_err_cnt;
    logic [TMO_W-1:0] r_tmo;

    logic        w_in_frame;
    logic        w_timeout;
    logic        w_chk_ok;
    logic        w_decim_zero;
    logic        w_seq_last;
    logic        w_resp_load;
    logic [7:0]  w_resp_first;
    logic [3:0]  w_resp_cnt;
    logic        w_resp_next;
    logic        w_commit;
    logic        w_err_inc;

    assign w_in_frame   = (r_state == ST_CMD) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
    // A byte arriving in the expiry cycle takes precedence over the timeout
    assign w_timeout    = w_in_frame && !rx_dv && (r_tmo == TMO_MAX);
    assign w_chk_ok     = (rx_byte == r_xor);
    assign w_decim_zero = (r_cmd == OP_SET_DECIM) && (r_stage[15:0] == 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_resp_load  = 1'b0;
        w_resp_first = ACK_BYTE;
        w_resp_cnt   = 4'd0;
        w_resp_next  = 1'b0;
        w_commit     = 1'b0;
        w_err_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                    w_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_timeout) begin
                    w_next    = ST_IDLE;
                    w_err_inc = 1'b1;
                end else if (rx_dv) begin
                    if (op_known(rx_byte)) begin
                        w_next = (payload_len(rx_byte) == 4'd0) ? ST_CHK : ST_PAYLOAD;
                    end else begin
                        w_next       = ST_RESP;
                        w_resp_load  = 1'b1;
                        w_resp_first = NAK_BYTE;
                        w_err_inc    = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_timeout) begin
                    w_next    = ST_IDLE;
                    w_err_inc = 1'b1;
                end else if (rx_dv && (r_left == 4'd1)) begin
                    w_next = ST_CHK;
                end
            end
            ST_CHK: begin
                if (w_timeout) begin
                    w_next    = ST_IDLE;
                    w_err_inc = 1'b1;
                end else if (rx_dv) begin
                    w_next      = ST_RESP;
                    w_resp_load = 1'b1;
                    if (!w_chk_ok || w_decim_zero) begin
                        w_resp_first = NAK_BYTE;
                        w_err_inc    = 1'b1;
                    end else begin
                        w_commit   = 1'b1;
                        w_resp_cnt = (r_cmd == OP_READ_FREQ) ? 4'd8 : 4'd0;
                    end
                end
            end
            ST_RESP: begin
                w_next = ST_RESP_WAIT;
            end
            ST_RESP_WAIT: begin
                if (tx_done) begin
                    if (w_seq_last) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next      = ST_RESP;
                        w_resp_next = 1'b1;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd        <= 8'h00;
            r_left       <= 4'd0;
            r_xor        <= 8'h00;
            r_stage      <= 64'h0;
            r_phase      <= PHASE_INC_RST;
            r_decim      <= DECIM_RST;
            r_cfg_update <= 1'b0;
            r_err_cnt    <= 8'h00;
            r_tmo        <= '0;
        end else begin
            r_cfg_update <= 1'b0;

            if (rx_dv || !w_in_frame) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_MAX) begin
                r_tmo <= r_tmo + TMO_ONE;
            end

            if ((r_state == ST_CMD) && rx_dv) begin
                r_cmd  <= rx_byte;
                r_xor  <= rx_byte;
                r_left <= payload_len(rx_byte);
            end

            if ((r_state == ST_PAYLOAD) && rx_dv) begin
                r_stage <= {r_stage[55:0], rx_byte};
                r_xor   <= r_xor ^ rx_byte;
                r_left  <= r_left - 4'd1;
            end

            if (w_commit) begin
                if (r_cmd == OP_SET_FREQ) begin
                    r_phase      <= r_stage;
                    r_cfg_update <= 1'b1;
                end else if (r_cmd == OP_SET_DECIM) begin
                    r_decim      <= r_stage[15:0];
                    r_cfg_update <= 1'b1;
                end
            end

            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    sdr_tx_seq u_tx_seq (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_resp_load),
        .i_first (w_resp_first),
        .i_count (w_resp_cnt),
        .i_src   (r_phase),
        .i_next  (w_resp_next),
        .o_byte  (tx_byte),
        .o_last  (w_seq_last)
    );

    assign tx_dv            = (r_state == ST_RESP);
    assign phase_inc        = r_phase;
    assign decimation_ratio = r_decim;
    assign cfg_update       = r_cfg_update;
    assign err_cnt          = r_err_cnt;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Self-checking bench for sdr_tune_ctrl: frame-level reference model, per-cycle
// output compare, UART-TX responder with response scoreboard, literal pins.
module tb_sdr_tune_ctrl;

    localparam int          TMO  = 400;
    localparam int          TXD  = 10;
    localparam logic [63:0] PRST = 64'h00000C56106EA3BC;
    localparam logic [15:0] DRST = 16'd1024;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;

    logic        clk;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic [63:0] phase_inc;
    logic [15:0] decimation_ratio;
    logic        cfg_update;
    logic [7:0]  err_cnt;
    logic [2:0]  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    logic [7:0]  frm[$];
    logic [63:0] exp_phase;
    logic [15:0] exp_decim;
    logic [7:0]  exp_err;
    logic        exp_upd;
    logic        exp_first_tx;
    logic        chk_en;
    logic        err_chk_en;
    logic        busy;
    logic [7:0]  held_byte;
    logic [63:0] rb;

    sdr_tune_ctrl #(
        .PHASE_INC_RST (PRST),
        .DECIM_RST     (DRST),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_dv            (rx_dv),
        .rx_byte          (rx_byte),
        .tx_dv            (tx_dv),
        .tx_byte          (tx_byte),
        .tx_done          (tx_done),
        .phase_inc        (phase_inc),
        .decimation_ratio (decimation_ratio),
        .cfg_update       (cfg_update),
        .err_cnt          (err_cnt),
        .dbg_state        (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_phase    = PRST;
        exp_decim    = DRST;
        exp_err      = 8'd0;
        exp_upd      = 1'b0;
        exp_first_tx = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_nak();
        exp_q.push_back(NAK);
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endtask

    // Whole-frame effect computed from the command rules
    task automatic model_frame();
        logic [7:0]  cmd;
        logic [7:0]  x;
        logic [63:0] pl;
        int          len;
        cmd = frm[1];
        if (cmd != 8'h01 && cmd != 8'h02 && cmd != 8'h03) begin
            model_nak();
        end else begin
            len = (cmd == 8'h01) ? 8 : (cmd == 8'h02) ? 2 : 0;
            x   = cmd;
            pl  = 64'h0;
            for (int i = 0; i < len; i++) begin
                pl = (pl << 8) | 64'(frm[2 + i]);
                x  = x ^ frm[2 + i];
            end
            if (frm[2 + len] != x) begin
                model_nak();
            end else if (cmd == 8'h01) begin
                exp_phase = pl;
                exp_upd   = 1'b1;
                exp_q.push_back(ACK);
            end else if (cmd == 8'h02) begin
                if (pl[15:0] == 16'h0000) begin
                    model_nak();
                end else begin
                    exp_decim = pl[15:0];
                    exp_upd   = 1'b1;
                    exp_q.push_back(ACK);
                end
            end else begin
                exp_q.push_back(ACK);
                for (int k = 7; k >= 0; k--) exp_q.push_back(exp_phase[8*k +: 8]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic send_raw();
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
    endtask

    task automatic send_frame();
        send_raw();
        model_frame();
        exp_first_tx = 1'b1;
        @(posedge clk);
        #1;
        exp_upd      = 1'b0;
        exp_first_tx = 1'b0;
    endtask

    task automatic wait_resp();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        check("resp_drain", 64'(done), 64'd1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase_inc", phase_inc, exp_phase);
            check("decimation_ratio", 64'(decimation_ratio), 64'(exp_decim));
            check("cfg_update", 64'(cfg_update), 64'(exp_upd));
            if (err_chk_en) check("err_cnt", 64'(err_cnt), 64'(exp_err));
            if (exp_first_tx) check("resp_latency", 64'(tx_dv), 64'd1);
        end
    end

    // UART-TX responder and response scoreboard
    initial begin
        tx_done = 1'b0;
        busy    = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (chk_en && tx_dv) begin
                held_byte = tx_byte;
                cap_q.push_back(tx_byte);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got tx_byte %h, expected no transmission at %0t", tx_byte, $time);
                end else begin
                    check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
                end
                busy = 1'b1;
                repeat (TXD) begin
                    @(negedge clk);
                    check("tx_hold", 64'(tx_byte), 64'(held_byte));
                    check("tx_dv_gap", 64'(tx_dv), 64'd0);
                end
                tx_done = 1'b1;
                busy    = 1'b0;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        rx_dv      = 1'b0;
        rx_byte    = 8'h00;
        chk_en     = 1'b0;
        err_chk_en = 1'b1;
        model_reset();

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_tx_dv", 64'(tx_dv), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(sdr_cmd_pkg::ST_IDLE));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (10000) @(posedge clk);
        #1;
        check("idle_phase", phase_inc, 64'h00000C56106EA3BC);
        check("idle_decim", 64'(decimation_ratio), 64'd1024);
        check("idle_err", 64'(err_cnt), 64'd0);

        frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_frame();
        wait_resp();
        check("lit_freq1", phase_inc, 64'h0000000012345678);
        check("lit_freq1_decim", 64'(decimation_ratio), 64'd1024);

        frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02};
        send_frame();
        wait_resp();
        check("lit_decim0_err", 64'(err_cnt), 64'd1);
        check("lit_decim0_decim", 64'(decimation_ratio), 64'd1024);

        frm = '{8'hA5, 8'h02, 8'h02, 8'h00, 8'h00};
        send_frame();
        wait_resp();
        check("lit_decim512", 64'(decimation_ratio), 64'd512);

        frm = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        send_frame();
        wait_resp();
        check("lit_badchk_err", 64'(err_cnt), 64'd2);
        check("lit_badchk_phase", phase_inc, 64'h0000000012345678);

        frm = '{8'hA5, 8'h07};
        send_frame();
        wait_resp();
        check("lit_badop_err", 64'(err_cnt), 64'd3);

        cap_q.delete();
        frm = '{8'hA5, 8'h03, 8'h03};
        send_frame();
        frm = '{8'hA5, 8'h02, 8'h00, 8'h09, 8'h0B};
        send_raw();
        wait_resp();
        check("lit_rb_count", 64'(cap_q.size()), 64'd9);
        if (cap_q.size() == 9) begin
            check("lit_rb_ack", 64'(cap_q[0]), 64'h06);
            rb = 64'h0;
            for (int k = 1; k <= 8; k++) rb = {rb[55:0], cap_q[k]};
            check("lit_rb_value", rb, 64'h0000000012345678);
        end
        check("lit_rb_decim", 64'(decimation_ratio), 64'd512);

        frm = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        send_raw();
        repeat (TMO - 3) @(posedge clk);
        #1;
        err_chk_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        exp_err    = exp_err + 8'd1;
        err_chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("lit_tmo_err", 64'(err_cnt), 64'd4);

        frm = '{8'hA5, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        send_frame();
        wait_resp();
        check("lit_freq2", phase_inc, 64'h0123456789ABCDEF);

        frm = '{8'hA5, 8'h02, 8'h01};
        send_raw();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("lit_rst_phase", phase_inc, 64'h00000C56106EA3BC);
        check("lit_rst_state", 64'(dbg_state), 64'(sdr_cmd_pkg::ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("lit_rst_decim", 64'(decimation_ratio), 64'd1024);
        check("lit_rst_err", 64'(err_cnt), 64'd0);

        frm = '{8'hA5, 8'h02, 8'h00, 8'h07, 8'h05};
        send_frame();
        wait_resp();
        check("lit_decim7", 64'(decimation_ratio), 64'd7);

        repeat (20) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
